// File: rtl/if_ahb_prefetch.sv
// ---------------------------------------------------------------------------
// if_ahb_prefetch
// Pipelined AHB-lite instruction-fetch master with a small prefetch FIFO,
// sitting between the IFU and the IDU. It owns the sequential fetch PC, keeps
// one data phase in flight while presenting the next address phase, buffers
// fetched words and tags each word with its bus error status.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   ce_i                fetch enable; low stops new address phases
//   flush_i, flush_pc_i redirect: drop FIFO and in-flight data, restart at flush_pc_i
//   stall_i             IDU not accepting; an entry pops when valid_o & !stall_i
//   valid_o, pc_o,
//   inst_o, err_o       head-of-FIFO entry (pc/inst/err forced to 0 when empty)
//   mst_h*_o            AHB-lite master address-phase outputs
//   mst_hready_i,
//   mst_hresp_i,
//   mst_hrdata_i        AHB-lite slave responses
// ---------------------------------------------------------------------------
module if_ahb_prefetch #(
  parameter int                ADDR_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [3:0]        HPROT_VAL  = 4'b0010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              stall_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [31:0]       inst_o,
  output logic              err_o,
  output logic              mst_hsel_o,
  output logic [1:0]        mst_htrans_o,
  output logic [ADDR_W-1:0] mst_haddr_o,
  output logic              mst_hwrite_o,
  output logic [2:0]        mst_hsize_o,
  output logic [2:0]        mst_hburst_o,
  output logic [3:0]        mst_hprot_o,
  input  logic              mst_hready_i,
  input  logic              mst_hresp_i,
  input  logic [31:0]       mst_hrdata_i
);

  localparam int                PTR_W   = $clog2(FIFO_DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]    DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [1:0]        HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]        HTRANS_NONSEQ = 2'b10;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;

  // Address phase that was presented with HREADY low and must be repeated.
  logic              hold_q, hold_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic              hold_discard_q, hold_discard_d;

  // Data phase currently owed by the slave.
  logic              dp_pending_q, dp_pending_d;
  logic [ADDR_W-1:0] dp_addr_q, dp_addr_d;
  logic              dp_discard_q, dp_discard_d;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [31:0]       fifo_data_q [FIFO_DEPTH];
  logic              fifo_err_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [CNT_W:0]    occupancy;
  logic              credit_ok;
  logic              issue;
  logic              addr_valid;
  logic              addr_accept;
  logic              dp_done;
  logic              push;
  logic              err_push;
  logic              pop;

  assign mst_hwrite_o = 1'b0;
  assign mst_hsize_o  = 3'b010;
  assign mst_hburst_o = 3'b000;
  assign mst_hprot_o  = HPROT_VAL;
  assign mst_hsel_o   = ce_i | hold_q | dp_pending_q;

  // Bus-side handshake. A new request is only issued when every word already
  // queued or in flight still leaves a free FIFO slot, so a push never hits a
  // full FIFO. Nothing new goes out in the flush cycle because fetch_pc_q
  // still holds the stale address then.
  always_comb begin
    occupancy    = {1'b0, count_q} + {{CNT_W{1'b0}}, dp_pending_q};
    credit_ok    = occupancy < DEPTH_V;
    issue        = (state_q == S_FETCH) & ce_i & ~flush_i & ~hold_q & credit_ok;
    addr_valid   = hold_q | issue;
    mst_htrans_o = addr_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    mst_haddr_o  = '0;
    if (hold_q) begin
      mst_haddr_o = hold_addr_q;
    end else if (issue) begin
      mst_haddr_o = fetch_pc_q;
    end
    addr_accept  = addr_valid & mst_hready_i;
    dp_done      = dp_pending_q & mst_hready_i;
    push         = dp_done & ~dp_discard_q & ~flush_i;
    err_push     = push & mst_hresp_i;
    pop          = (count_q != '0) & ~stall_i & ~flush_i;
  end

  // Fetch state machine: a flush always wins, an error entry parks the
  // fetcher in HALT until the next redirect.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ce_i ? S_FETCH : S_IDLE;
    end else if (err_push) begin
      state_d = S_HALT;
    end else begin
      case (state_q)
        S_IDLE:  if (ce_i) state_d = S_FETCH;
        S_FETCH: if (!ce_i && !hold_q) state_d = S_IDLE;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next-state for the PC, the held address phase, the pending data phase
  // and the FIFO pointers. A held phase that was flushed completes on the bus
  // but must not advance the PC, since the PC already holds the redirect.
  // Anything accepted together with an error push is thrown away, because
  // the fetcher halts at that error.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (flush_i) begin
      fetch_pc_d = flush_pc_i;
    end else if (addr_accept && !hold_discard_q) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end

    hold_d         = 1'b0;
    hold_addr_d    = hold_addr_q;
    hold_discard_d = 1'b0;
    if (addr_valid && !mst_hready_i) begin
      hold_d         = 1'b1;
      hold_addr_d    = mst_haddr_o;
      hold_discard_d = hold_discard_q | flush_i;
    end

    dp_pending_d = dp_pending_q;
    dp_addr_d    = dp_addr_q;
    dp_discard_d = dp_discard_q;
    if (addr_accept) begin
      dp_pending_d = 1'b1;
      dp_addr_d    = mst_haddr_o;
      dp_discard_d = flush_i | err_push | hold_discard_q;
    end else if (dp_done) begin
      dp_pending_d = 1'b0;
      dp_discard_d = 1'b0;
    end else if (flush_i && dp_pending_q) begin
      dp_discard_d = 1'b1;
    end

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      fetch_pc_q     <= RESET_PC;
      hold_q         <= 1'b0;
      hold_addr_q    <= '0;
      hold_discard_q <= 1'b0;
      dp_pending_q   <= 1'b0;
      dp_addr_q      <= '0;
      dp_discard_q   <= 1'b0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      hold_q         <= hold_d;
      hold_addr_q    <= hold_addr_d;
      hold_discard_q <= hold_discard_d;
      dp_pending_q   <= dp_pending_d;
      dp_addr_q      <= dp_addr_d;
      dp_discard_q   <= dp_discard_d;
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      count_q        <= count_d;
    end
  end

  // Storage needs no reset: count_q alone decides what is visible.
  // Error entries carry a zero instruction.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= dp_addr_q;
      fifo_data_q[wptr_q] <= mst_hresp_i ? 32'h0 : mst_hrdata_i;
      fifo_err_q[wptr_q]  <= mst_hresp_i;
    end
  end

  always_comb begin
    valid_o = (count_q != '0);
    pc_o    = '0;
    inst_o  = '0;
    err_o   = 1'b0;
    if (valid_o) begin
      pc_o   = fifo_addr_q[rptr_q];
      inst_o = fifo_data_q[rptr_q];
      err_o  = fifo_err_q[rptr_q];
    end
  end

endmodule

// File: tb/tb_if_ahb_prefetch.sv
module tb_if_ahb_prefetch;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i, flush_i, stall_i;
  logic [31:0] flush_pc_i;
  logic        valid_o, err_o;
  logic [31:0] pc_o, inst_o;
  logic        mst_hsel_o, mst_hwrite_o;
  logic [1:0]  mst_htrans_o;
  logic [31:0] mst_haddr_o;
  logic [2:0]  mst_hsize_o, mst_hburst_o;
  logic [3:0]  mst_hprot_o;
  logic        mst_hready_i, mst_hresp_i;
  logic [31:0] mst_hrdata_i;

  if_ahb_prefetch #(
    .ADDR_W(ADDR_W), .FIFO_DEPTH(4), .RESET_PC(RESET_PC), .HPROT_VAL(4'b0010)
  ) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .stall_i(stall_i), .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o), .err_o(err_o),
    .mst_hsel_o(mst_hsel_o), .mst_htrans_o(mst_htrans_o), .mst_haddr_o(mst_haddr_o),
    .mst_hwrite_o(mst_hwrite_o), .mst_hsize_o(mst_hsize_o), .mst_hburst_o(mst_hburst_o),
    .mst_hprot_o(mst_hprot_o), .mst_hready_i(mst_hready_i), .mst_hresp_i(mst_hresp_i),
    .mst_hrdata_i(mst_hrdata_i)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  // Stimulus values applied at the next step
  logic        driveCe, driveStall, driveFlush;
  logic [31:0] driveFlushPc;

  // Slave model state and configuration
  logic        slValid, slErr;
  logic [31:0] slAddr;
  int          slWait;
  logic [31:0] waitAddr, errAddr;
  int          waitN, errMode;
  logic        rndWaits;

  // Values sampled from the DUT each cycle
  logic [1:0]  sTrans;
  logic [31:0] sAddr, sPc, sInst;
  logic        sValid, sErr, sHready;

  // Reference model: the expected instruction stream and issue stream
  logic [31:0] expPc, expIssue, heldAddr, lastStartAddr;
  logic        halted, prevHeld;
  int          issueStarts, popCount;

  typedef struct {
    logic        ce;
    logic        stall;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [31:0] dataFn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic errFn(input logic [31:0] a);
    if (errMode == 1) return a == errAddr;
    if (errMode == 2) return ((a >> 2) % 23) == 7;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Stream-level expectations: pops follow the PC sequence from the last
  // redirect, errors stop the stream until the next flush, fresh address
  // phases follow the same sequence and held phases never change.
  task automatic modelCheck();
    logic popNow, e;
    popNow = sValid && !driveStall && !driveFlush;
    if (halted) checkOutput("halt_valid", sValid, 0);
    if (!sValid) checkOutput("empty_inst", sInst, 0);
    if (popNow) begin
      e = errFn(expPc);
      checkOutput("pop_pc", sPc, expPc);
      checkOutput("pop_inst", sInst, e ? 32'h0 : dataFn(expPc));
      checkOutput("pop_err", sErr, e);
      expPc = expPc + 32'd4;
      popCount++;
      if (e) halted = 1'b1;
    end
    if (prevHeld) begin
      checkOutput("hold_trans", sTrans, 2'b10);
      checkOutput("hold_addr", sAddr, heldAddr);
    end else if (sTrans == 2'b10) begin
      checkOutput("issue_allowed", {driveCe, driveFlush, halted}, 3'b100);
      checkOutput("issue_addr", sAddr, expIssue);
      expIssue = expIssue + 32'd4;
      issueStarts++;
      lastStartAddr = sAddr;
    end
    prevHeld = (sTrans == 2'b10) && !sHready;
    heldAddr = sAddr;
    if (driveFlush) begin
      expPc    = driveFlushPc;
      expIssue = driveFlushPc;
      halted   = 1'b0;
    end
  endtask

  // One clock cycle: drive at the falling edge, sample shortly after, then
  // advance the slave to what happens at the coming rising edge.
  task automatic applyStimulus();
    @(negedge clk);
    ce_i         = driveCe;
    stall_i      = driveStall;
    flush_i      = driveFlush;
    flush_pc_i   = driveFlushPc;
    mst_hready_i = !slValid || (slWait == 0);
    mst_hresp_i  = slValid && mst_hready_i && slErr;
    mst_hrdata_i = (slValid && !slErr) ? dataFn(slAddr) : $urandom();
    #1;
    sTrans  = mst_htrans_o;
    sAddr   = mst_haddr_o;
    sValid  = valid_o;
    sPc     = pc_o;
    sInst   = inst_o;
    sErr    = err_o;
    sHready = mst_hready_i;
    modelCheck();
    if (slValid) begin
      if (sHready) slValid = 1'b0;
      else slWait--;
    end
    if (sTrans == 2'b10 && sHready) begin
      slValid = 1'b1;
      slAddr  = sAddr;
      slErr   = errFn(sAddr);
      slWait  = rndWaits ? int'($urandom_range(0, 2)) : ((sAddr == waitAddr) ? waitN : 0);
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    driveCe = 1'b0; driveStall = 1'b0; driveFlush = 1'b0; driveFlushPc = 32'h0;
    ce_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0;
    mst_hready_i = 1'b1; mst_hresp_i = 1'b0; mst_hrdata_i = 32'h0;
    repeat (2) @(negedge clk);
    slValid = 1'b0; slErr = 1'b0; slWait = 0; slAddr = 32'h0;
    expPc = RESET_PC; expIssue = RESET_PC; halted = 1'b0; prevHeld = 1'b0;
    heldAddr = 32'h0; issueStarts = 0; popCount = 0; lastStartAddr = 32'h0;
    waitAddr = 32'hFFFF_FFFF; waitN = 0; errMode = 0; errAddr = 32'hFFFF_FFFF; rndWaits = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int heldC, startsBefore, found;

    vecs[0] = '{1'b1, 1'b0, 2'b00, 32'h00, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 2'b10, 32'h00, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 2'b10, 32'h04, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 2'b10, 32'h08, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 2'b10, 32'h0C, 1'b1, 32'h4};
    vecs[5] = '{1'b1, 1'b0, 2'b10, 32'h10, 1'b1, 32'h8};
    vecs[6] = '{1'b1, 1'b0, 2'b10, 32'h14, 1'b1, 32'hC};

    // Reset values and constant bus attributes
    applyReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_valid", valid_o, 0);
    checkOutput("rst_pc", pc_o, 0);
    checkOutput("rst_inst", inst_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_htrans", mst_htrans_o, 0);
    checkOutput("rst_haddr", mst_haddr_o, 0);
    checkOutput("rst_hsel", mst_hsel_o, 0);
    checkOutput("const_attr", {mst_hwrite_o, mst_hsize_o, mst_hburst_o, mst_hprot_o},
                {1'b0, 3'b010, 3'b000, 4'b0010});
    applyReset();

    // Zero-wait streaming from RESET_PC
    for (int i = 0; i < 7; i++) begin
      driveCe = vecs[i].ce;
      driveStall = vecs[i].stall;
      applyStimulus();
      checkOutput($sformatf("t1_trans%0d", i), sTrans, vecs[i].trans);
      checkOutput($sformatf("t1_addr%0d", i), sAddr, vecs[i].addr);
      checkOutput($sformatf("t1_valid%0d", i), sValid, vecs[i].valid);
      checkOutput($sformatf("t1_pc%0d", i), sPc, vecs[i].pc);
    end

    // Stall fills the FIFO, then drains in order and refetches at 0x10
    applyReset();
    driveCe = 1'b1; driveStall = 1'b1;
    repeat (10) applyStimulus();
    checkOutput("t2_idle", sTrans, 2'b00);
    checkOutput("t2_valid", sValid, 1);
    checkOutput("t2_head", sPc, 32'h0);
    checkOutput("t2_starts", issueStarts, 4);
    driveStall = 1'b0;
    startsBefore = issueStarts;
    for (int i = 0; i < 6 && issueStarts == startsBefore; i++) applyStimulus();
    checkOutput("t2_resume", (issueStarts != startsBefore) ? lastStartAddr : 32'hFFFF_FFFF, 32'h10);
    repeat (6) applyStimulus();
    checkOutput("t2_pops", (popCount >= 5) ? 1 : 0, 1);

    // Three wait states on the data phase of 0x8
    applyReset();
    waitAddr = 32'h8; waitN = 3;
    driveCe = 1'b1;
    heldC = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      if (sTrans == 2'b10 && sAddr == 32'hC && !sHready) heldC++;
    end
    checkOutput("t3_held", heldC, 3);
    checkOutput("t3_pops", (popCount >= 10) ? 1 : 0, 1);

    // Flush while 0x14 is in its data phase and two entries are queued
    applyReset();
    waitAddr = 32'h14; waitN = 6;
    driveCe = 1'b1;
    for (int i = 0; i < 7; i++) begin
      driveStall = (i == 5);
      applyStimulus();
    end
    driveStall = 1'b1; driveFlush = 1'b1; driveFlushPc = 32'h100;
    applyStimulus();
    checkOutput("t4_pending14", {slValid, slAddr}, {1'b1, 32'h14});
    checkOutput("t4_head", {sValid, sPc}, {1'b1, 32'hC});
    driveFlush = 1'b0; driveStall = 1'b0;
    applyStimulus();
    checkOutput("t4_flush_valid", sValid, 0);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      applyStimulus();
      if (sValid) found = 1;
    end
    checkOutput("t4_redirect", found ? {sPc, sInst} : 64'h0, {32'h100, dataFn(32'h100)});

    // Error response on 0xC halts fetching until a redirect
    applyReset();
    errMode = 1; errAddr = 32'hC;
    driveCe = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      applyStimulus();
      if (sValid && sErr) found = 1;
    end
    checkOutput("t5_err_entry", found ? {sPc, sInst} : 64'h1, {32'hC, 32'h0});
    startsBefore = issueStarts;
    repeat (10) applyStimulus();
    checkOutput("t5_no_issue", issueStarts - startsBefore, 0);
    checkOutput("t5_drained", sValid, 0);
    driveFlush = 1'b1; driveFlushPc = 32'h200;
    applyStimulus();
    driveFlush = 1'b0;
    found = 0;
    for (int i = 0; i < 15 && found == 0; i++) begin
      applyStimulus();
      if (sValid) found = 1;
    end
    checkOutput("t5_restart", found ? sPc : 32'h1, 32'h200);

    // Reset in the middle of a waited data phase
    applyReset();
    waitAddr = 32'h8; waitN = 4;
    driveCe = 1'b1;
    repeat (5) applyStimulus();
    checkOutput("t6_pending", {slValid, slAddr}, {1'b1, 32'h8});
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_valid", valid_o, 0);
    checkOutput("t6_htrans", mst_htrans_o, 0);
    checkOutput("t6_haddr", mst_haddr_o, 0);
    checkOutput("t6_pc_inst", {pc_o, inst_o}, 64'h0);
    applyReset();
    driveCe = 1'b1;
    for (int i = 0; i < 5 && issueStarts == 0; i++) applyStimulus();
    checkOutput("t6_first", (issueStarts != 0) ? lastStartAddr : 32'hFFFF_FFFF, RESET_PC);

    // Randomised traffic against the stream model
    applyReset();
    errMode = 2; rndWaits = 1'b1;
    for (int i = 0; i < 800; i++) begin
      driveCe      = ($urandom_range(0, 9) != 0);
      driveStall   = ($urandom_range(0, 9) < 3);
      driveFlush   = ($urandom_range(0, 39) == 0);
      driveFlushPc = 32'h1000 + ($urandom_range(0, 255) << 2);
      applyStimulus();
    end
    checkOutput("rnd_progress", (popCount >= 60) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
